// File: rtl/iccm_boot_loader_if.sv
// Signal bundle between a UART byte source and the ICCM boot loader.
// Carries the byte strobe in and the ICCM write port and status flags out.
interface iccm_boot_loader_if #(
    parameter int unsigned AddrWidth = 12
);
    logic                 rx_dv;
    logic [7:0]           rx_byte;
    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic                 prog_done;
    logic                 core_rst_n;

    modport master (
        output rx_dv, rx_byte,
        input  req, we, addr, wdata, prog_done, core_rst_n
    );

    modport slave (
        input  rx_dv, rx_byte,
        output req, we, addr, wdata, prog_done, core_rst_n
    );
endinterface

// File: rtl/iccm_boot_loader.sv
// Assembles little-endian UART bytes into 32-bit words and writes them to ICCM
// at ascending addresses until the sentinel word arrives or the ICCM is full.
module iccm_boot_loader #(
    parameter int unsigned AddrWidth = 12,
    parameter logic [31:0] EndWord   = 32'h0000_0FFF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_dv_i,
    input  logic [7:0]           rx_byte_i,
    output logic                 req_o,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [31:0]          wdata_o,
    output logic                 prog_done_o,
    output logic                 core_rst_no
);

    typedef enum logic [1:0] {
        RECV,
        WRITE,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [31:0]          asm_q, asm_d;
    logic [AddrWidth-1:0] addr_cnt_q, addr_cnt_d;
    logic [31:0]          wbuf_q, wbuf_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 done_q, done_d;
    logic                 core_rst_n_q, core_rst_n_d;
    logic [31:0]          word_full;

    // Completed word as seen on the strobe that delivers the fourth byte.
    assign word_full = {rx_byte_i, asm_q[23:0]};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        addr_cnt_d   = addr_cnt_q;
        wbuf_d       = wbuf_q;
        req_d        = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        done_d       = done_q;
        core_rst_n_d = core_rst_n_q;

        unique case (state_q)
            RECV, WRITE: begin
                if (state_q == WRITE) begin
                    if (addr_cnt_q == '1) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        core_rst_n_d = 1'b1;
                    end else begin
                        addr_cnt_d = addr_cnt_q + 1'b1;
                        state_d    = RECV;
                    end
                end
                // A byte arriving during WRITE starts the next word; the
                // write port registers were loaded a cycle earlier.
                if (rx_dv_i) begin
                    asm_d[{idx_q, 3'b000} +: 8] = rx_byte_i;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wbuf_d = word_full;
                        if (word_full == EndWord) begin
                            state_d      = DONE;
                            done_d       = 1'b1;
                            core_rst_n_d = 1'b1;
                        end else begin
                            state_d = WRITE;
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            addr_d  = addr_cnt_q;
                            wdata_d = word_full;
                        end
                    end
                end
            end
            DONE: begin
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RECV;
            idx_q        <= '0;
            asm_q        <= '0;
            addr_cnt_q   <= '0;
            wbuf_q       <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            addr_cnt_q   <= addr_cnt_d;
            wbuf_q       <= wbuf_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign req_o       = req_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign prog_done_o = done_q;
    assign core_rst_no = core_rst_n_q;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Drives one random byte stream into two loaders (full-size and 4-word ICCM)
// and compares every output each cycle against a word-level reference model.
module tb_iccm_boot_loader;

    localparam logic [31:0] END_WORD = 32'h0000_0FFF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    iccm_boot_loader_if #(.AddrWidth(12)) bus_a ();
    iccm_boot_loader_if #(.AddrWidth(2))  bus_b ();

    iccm_boot_loader #(.AddrWidth(12), .EndWord(END_WORD)) dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_dv_i     (bus_a.rx_dv),
        .rx_byte_i   (bus_a.rx_byte),
        .req_o       (bus_a.req),
        .we_o        (bus_a.we),
        .addr_o      (bus_a.addr),
        .wdata_o     (bus_a.wdata),
        .prog_done_o (bus_a.prog_done),
        .core_rst_no (bus_a.core_rst_n)
    );

    iccm_boot_loader #(.AddrWidth(2), .EndWord(END_WORD)) dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_dv_i     (bus_b.rx_dv),
        .rx_byte_i   (bus_b.rx_byte),
        .req_o       (bus_b.req),
        .we_o        (bus_b.we),
        .addr_o      (bus_b.addr),
        .wdata_o     (bus_b.wdata),
        .prog_done_o (bus_b.prog_done),
        .core_rst_no (bus_b.core_rst_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words written so far, pending byte count, and the
    // write port contents expected to be visible this cycle.
    int          cap[2] = '{4096, 4};
    bit          m_req[2];
    bit          m_done[2];
    int          m_cnt[2];
    int          m_next[2];
    logic [31:0] m_word[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_req[k]   = 1'b0;
            m_done[k]  = 1'b0;
            m_cnt[k]   = 0;
            m_next[k]  = 0;
            m_word[k]  = '0;
            m_addr[k]  = '0;
            m_wdata[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input logic dv, input logic [7:0] b);
        bit was_req;
        was_req  = m_req[k];
        m_req[k] = 1'b0;
        if (!m_done[k]) begin
            if (dv) begin
                m_word[k] = m_word[k] | (32'(b) << (8 * m_cnt[k]));
                m_cnt[k]++;
                if (m_cnt[k] == 4) begin
                    m_cnt[k] = 0;
                    if (m_word[k] == END_WORD) begin
                        m_done[k] = 1'b1;
                    end else begin
                        m_req[k]   = 1'b1;
                        m_addr[k]  = 32'(m_next[k]);
                        m_wdata[k] = m_word[k];
                    end
                    m_word[k] = '0;
                end
            end
            if (was_req) begin
                m_next[k]++;
                if (m_next[k] == cap[k]) m_done[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, " a.req"},   32'(bus_a.req),        32'(m_req[0]));
        check({ph, " a.we"},    32'(bus_a.we),         32'(m_req[0]));
        check({ph, " a.addr"},  32'(bus_a.addr),       m_addr[0]);
        check({ph, " a.wdata"}, bus_a.wdata,           m_wdata[0]);
        check({ph, " a.done"},  32'(bus_a.prog_done),  32'(m_done[0]));
        check({ph, " a.crst"},  32'(bus_a.core_rst_n), 32'(m_done[0]));
        check({ph, " b.req"},   32'(bus_b.req),        32'(m_req[1]));
        check({ph, " b.we"},    32'(bus_b.we),         32'(m_req[1]));
        check({ph, " b.addr"},  32'(bus_b.addr),       m_addr[1]);
        check({ph, " b.wdata"}, bus_b.wdata,           m_wdata[1]);
        check({ph, " b.done"},  32'(bus_b.prog_done),  32'(m_done[1]));
        check({ph, " b.crst"},  32'(bus_b.core_rst_n), 32'(m_done[1]));
    endtask

    task automatic drive(input string ph, input logic dv, input logic [7:0] b);
        bus_a.rx_dv   = dv;
        bus_a.rx_byte = b;
        bus_b.rx_dv   = dv;
        bus_b.rx_byte = b;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, dv, b);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic idle(input string ph, input int n);
        for (int i = 0; i < n; i++) drive(ph, 1'b0, 8'($urandom));
    endtask

    task automatic send_word(input string ph, input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            idle(ph, $urandom_range(max_gap, 0));
            drive(ph, 1'b1, w[8*i +: 8]);
        end
    endtask

    task automatic reset_pulse(input string ph);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({ph, " rst"});
        @(posedge clk);
        @(negedge clk);
        check_all({ph, " rst_hold"});
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == END_WORD) w = w ^ 32'h1;
        return w;
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus_a.rx_dv   = 1'b0;
        bus_a.rx_byte = '0;
        bus_b.rx_dv   = 1'b0;
        bus_b.rx_byte = '0;
        #1;
        model_reset();
        check_all("init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        send_word("w0", 32'h1234_5678, 0);
        idle("w0", 3);
        send_word("b2b", rand_word(), 0);
        send_word("b2b", rand_word(), 0);
        idle("b2b", 2);
        send_word("fill", rand_word(), 2);
        send_word("fill", rand_word(), 2);
        idle("fill", 3);

        drive("part", 1'b1, 8'($urandom));
        drive("part", 1'b1, 8'($urandom));
        reset_pulse("part");
        send_word("after", rand_word(), 1);
        reset_pulse("midwr");

        for (int i = 0; i < 6; i++) send_word("rand", rand_word(), 2);
        idle("rand", 2);

        reset_pulse("sent");
        send_word("sent", rand_word(), 1);
        send_word("sent", rand_word(), 0);
        send_word("sent", END_WORD, 1);
        idle("sent", 2);
        send_word("ign", rand_word(), 0);
        send_word("ign", rand_word(), 1);
        idle("ign", 2);

        reset_pulse("first");
        send_word("first", END_WORD, 0);
        send_word("first", rand_word(), 0);
        idle("first", 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iccm_boot_loader.md
ICCM_BOOT_LOADER -- requirements
Module: iccm_boot_loader

Interface
REQ-001 SHALL have parameter AddrWidth, default 12, giving the ICCM word-address width.
REQ-002 SHALL have parameter EndWord, default 32'h0000_0FFF, the terminating sentinel word.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port rx_dv_i, input, 1, one-cycle strobe qualifying rx_byte_i, from the UART receiver.
REQ-006 SHALL have port rx_byte_i, input, 8, the received byte.
REQ-007 SHALL have port req_o, output, 1, ICCM request strobe.
REQ-008 SHALL have port we_o, output, 1, ICCM write enable.
REQ-009 SHALL have port addr_o, output, AddrWidth, ICCM word address.
REQ-010 SHALL have port wdata_o, output, 32, ICCM write data.
REQ-011 SHALL have port prog_done_o, output, 1, sticky programming-complete flag.
REQ-012 SHALL have port core_rst_no, output, 1, active-low core hold-reset, ANDed with the system reset at top level.

Function
REQ-013 SHALL implement a state machine with states RECV, WRITE, DONE; reset state RECV.
REQ-014 SHALL keep an assembly register (32 bits), a byte index (0..3), a word-address counter (AddrWidth bits) and a separate write-data register.
REQ-015 In RECV or WRITE, on rx_dv_i=1, SHALL place rx_byte_i in assembly bits [8*idx+7:8*idx] (little-endian, first byte = LSB) and increment idx.
REQ-016 On the strobe that fills idx 3, SHALL copy the completed word to the write-data register, clear idx to 0, and set the next state to WRITE, or to DONE if the word equals EndWord.
REQ-017 SHALL NOT write the EndWord sentinel to ICCM.
REQ-018 In WRITE, for exactly one cycle, SHALL drive req_o=1, we_o=1, addr_o=address counter, wdata_o=write-data register.
REQ-019 Write latency: req_o/we_o SHALL assert on the cycle immediately after the clock edge that captured the fourth byte.
REQ-020 On leaving WRITE, SHALL increment the address counter and return to RECV.
REQ-021 If the address written was 2^AddrWidth-1 (ICCM full), SHALL go to DONE instead of RECV; the address SHALL NOT wrap.
REQ-022 A byte strobed during the WRITE cycle SHALL be accepted as the next word's byte (no data loss; the write-data register is unaffected).
REQ-023 The buffered write and the next word's assembly SHALL proceed independently; back-to-back words at one byte per cycle SHALL be written without loss.
REQ-024 In DONE, SHALL assert prog_done_o=1 and core_rst_no=1, ignore rx_dv_i, and keep req_o=we_o=0; DONE SHALL be exited only by reset.
REQ-025 Outside WRITE, SHALL drive req_o=0 and we_o=0; addr_o and wdata_o SHALL hold their last values.
REQ-026 All outputs SHALL be driven from registers.

Reset
REQ-027 On rst_ni=0, asynchronously: state=RECV, idx=0, assembly=0, address=0, write data=0, req_o=0, we_o=0, addr_o=0, wdata_o=0, prog_done_o=0, core_rst_no=0.
REQ-028 Reset asserted mid-word or mid-write SHALL discard partial bytes; the write in flight SHALL be deasserted immediately.

Verification
REQ-029 Bytes 78,56,34,12 -> one cycle req_o=we_o=1, addr_o=0, wdata_o=32'h1234_5678; then addr 1.
REQ-030 Eight bytes on consecutive cycles (words A, B) -> two single-cycle writes, addr 0 = A, addr 1 = B, no byte lost.
REQ-031 Word 32'h0000_0FFF after two data words -> no write for the sentinel; prog_done_o=1, core_rst_no=1 the next cycle; later bytes ignored.
REQ-032 AddrWidth=2, five data words -> four writes to addresses 0..3, then DONE; the fifth word is not written.
REQ-033 Reset pulse after two bytes of a word -> all outputs at reset values; the next four bytes form a word written to addr 0.
REQ-034 First word equal to EndWord -> DONE with no write; addr_o stays 0.
